// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide unit for the execute stage.
// MULTU/MULT use shift-add on a 2*WIDTH accumulator; DIVU/DIV use restoring
// division, one result bit per cycle. Signed operations run on magnitudes, and a
// single SIGN cycle applies the result signs. hi/lo are registered and hold their
// value until the next operation completes.
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Operation context captured when a request is accepted
    logic [CNT_W-1:0] count_reg;
    logic             is_div_reg;
    logic             neg_q_reg;      // product / quotient must be negated
    logic             neg_r_reg;      // remainder must be negated (dividend was negative)
    logic             dz_reg;         // current op is a divide by zero
    logic [WIDTH-1:0] opb_reg;        // multiplicand or divisor magnitude

    // Working accumulator: {acc_hi, acc_lo} is the 2W product, or remainder/quotient
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;

    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             busy_reg, done_reg, div_zero_reg;

    // Request decode
    logic             idle_like;
    logic             accept;
    logic             op_div, op_signed;
    logic             rs_neg, rt_neg;
    logic             rt_zero;
    logic [WIDTH-1:0] abs_rs, abs_rt;
    logic             last_iter;

    assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign accept    = idle_like && start;
    assign op_div    = md_op[1];
    assign op_signed = md_op[0];
    assign rs_neg    = op_signed && rs_content[WIDTH-1];
    assign rt_neg    = op_signed && rt_content[WIDTH-1];
    assign rt_zero   = (rt_content == '0);
    // Negating MIN yields MIN again, which is the correct unsigned magnitude
    assign abs_rs    = rs_neg ? -rs_content : rs_content;
    assign abs_rt    = rt_neg ? -rt_content : rt_content;
    assign last_iter = (count_reg == CNT_W'(WIDTH - 1));

    // Multiply step: add the multiplicand when the low multiplier bit is set, then shift right
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = opb_reg[gi] & acc_lo_reg[0];
        end
    endgenerate

    assign mul_sum     = {1'b0, acc_hi_reg} + {1'b0, addend};
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and try to subtract
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_fits;
    logic [WIDTH-1:0] div_hi_next, div_lo_next;

    assign div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_trial   = div_shift - {1'b0, opb_reg};
    assign div_fits    = ~div_trial[WIDTH];
    assign div_hi_next = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_next = {acc_lo_reg[WIDTH-2:0], div_fits};

    // Sign fix-up applied in the SIGN cycle; divide-by-zero clears both flags so the raw
    // accumulator contents pass straight through
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign prod_raw = {acc_hi_reg, acc_lo_reg};
    assign prod_fix = neg_q_reg ? -prod_raw : prod_raw;
    assign quo_fix  = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
    assign rem_fix  = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
    assign res_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: kill aborts only while an op is in flight
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (op_div && rt_zero) ? ST_SIGN : ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (kill) begin
                    state_next = ST_IDLE;
                end else if (last_iter) begin
                    state_next = ST_SIGN;
                end
            end
            ST_SIGN: begin
                state_next = kill ? ST_IDLE : ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in RUN, commit results when leaving SIGN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dz_reg       <= 1'b0;
            opb_reg      <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        count_reg    <= '0;
                        is_div_reg   <= op_div;
                        div_zero_reg <= 1'b0;
                        if (op_div && rt_zero) begin
                            dz_reg     <= 1'b1;
                            neg_q_reg  <= 1'b0;
                            neg_r_reg  <= 1'b0;
                            opb_reg    <= rt_content;
                            acc_hi_reg <= rs_content;
                            acc_lo_reg <= '1;
                        end else begin
                            dz_reg     <= 1'b0;
                            neg_q_reg  <= rs_neg ^ rt_neg;
                            neg_r_reg  <= rs_neg;
                            opb_reg    <= op_div ? abs_rt : abs_rs;
                            acc_hi_reg <= '0;
                            acc_lo_reg <= op_div ? abs_rs : abs_rt;
                        end
                    end
                end
                ST_RUN: begin
                    if (!kill) begin
                        count_reg <= count_reg + 1'b1;
                        if (is_div_reg) begin
                            acc_hi_reg <= div_hi_next;
                            acc_lo_reg <= div_lo_next;
                        end else begin
                            acc_hi_reg <= mul_hi_next;
                            acc_lo_reg <= mul_lo_next;
                        end
                    end
                end
                ST_SIGN: begin
                    if (!kill) begin
                        hi_reg       <= res_hi;
                        lo_reg       <= res_lo;
                        div_zero_reg <= dz_reg;
                    end
                end
                default: begin
                    count_reg <= count_reg;
                end
            endcase
        end
    end

    // Status flags registered from the upcoming state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next == ST_RUN) || (state_next == ST_SIGN);
            done_reg <= (state_next == ST_DONE);
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: a 32-bit and an 8-bit instance, directed vectors,
// corner-case sequences and randomized ops checked against an arithmetic model.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] rs_content = '0;
    logic [31:0] rt_content = '0;
    logic        kill = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [1:0]  md_op8 = 2'b00;
    logic [7:0]  rs8 = '0;
    logic [7:0]  rt8 = '0;
    logic        kill8 = 1'b0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .rs_content(rs_content), .rt_content(rt_content), .kill(kill),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    alu_muldiv_seq #(.WIDTH(8), .CNT_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .md_op(md_op8),
        .rs_content(rs8), .rt_content(rt8), .kill(kill8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Arithmetic reference: plain signed/unsigned math on wide integers, truncated to w bits
    function automatic void ref_model(input int w, input logic [1:0] op,
                                      input logic [31:0] a_in, input logic [31:0] b_in,
                                      output logic [31:0] r_hi, output logic [31:0] r_lo,
                                      output logic r_dz);
        logic signed [127:0] a, b, p, q, r;
        logic [127:0] mask, t;
        mask = (128'd1 << w) - 128'd1;
        a = {96'd0, a_in} & mask;
        b = {96'd0, b_in} & mask;
        r_dz = 1'b0;
        if (b == 128'sd0 && op[1]) begin
            r_dz = 1'b1;
            r_lo = mask[31:0];
            t = {96'd0, a_in} & mask;
            r_hi = t[31:0];
        end else begin
            if (op[0] && a[w-1]) a = a - (128'sd1 <<< w);
            if (op[0] && b[w-1]) b = b - (128'sd1 <<< w);
            if (op[1]) begin
                q = a / b;
                r = a % b;
                t = q & mask;
                r_lo = t[31:0];
                t = r & mask;
                r_hi = t[31:0];
            end else begin
                p = a * b;
                t = p & mask;
                r_lo = t[31:0];
                t = (p >> w) & mask;
                r_hi = t[31:0];
            end
        end
    endfunction

    // Issue one op to both instances; report cycles from the accepting edge to done.
    // inject_k >= 0 drives a conflicting start into the 32-bit unit while it is busy.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_k, output int lat32, output int lat8,
                          output int busy_cnt, output logic dz_at_accept);
        @(negedge clk);
        start = 1'b1; md_op = op; rs_content = a; rt_content = b;
        start8 = 1'b1; md_op8 = op; rs8 = a[7:0]; rt8 = b[7:0];
        @(posedge clk); #1;
        start = 1'b0; start8 = 1'b0;
        lat32 = -1; lat8 = -1; busy_cnt = 0;
        dz_at_accept = div_zero;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == inject_k) begin
                start = 1'b1; md_op = ~op; rs_content = 32'h1234_5678; rt_content = 32'h3;
            end
            if (k == inject_k + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done && lat32 < 0) lat32 = k;
            if (done8 && lat8 < 0) lat8 = k;
            if (lat32 >= 0 && lat8 >= 0) break;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t        vecs [10];
    int          lat32, lat8, bcnt, exp_lat;
    logic        dza, m_dz;
    logic [31:0] m_hi, m_lo, old_hi, old_lo, ra, rb;
    logic [1:0]  rop;
    logic        seen_done;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b00, 32'd15,        32'd12,        32'd0,         32'd180,       1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
        vecs[3] = '{2'b11, 32'hFFFF_FFE9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFF5, 1'b0};
        vecs[4] = '{2'b10, 32'd1,         32'd35,        32'd1,         32'd0,         1'b0};
        vecs[5] = '{2'b10, 32'd23,        32'd0,         32'd23,        32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[7] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         1'b0};
        vecs[8] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9] = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, issued back to back
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat32, lat8, bcnt, dza);
            exp_lat = (vecs[i].op[1] && vecs[i].b == 32'd0) ? 1 : 33;
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, hi, lo, div_zero, lat32);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d_dz", i), 64'(div_zero), 64'(vecs[i].dz));
            check($sformatf("vec%0d_lat", i), 64'(lat32), 64'(exp_lat));
            check($sformatf("vec%0d_busy", i), 64'(bcnt), 64'(exp_lat));
            check($sformatf("vec%0d_dzclr", i), 64'(dza), 64'd0);
            ref_model(8, vecs[i].op, vecs[i].a, vecs[i].b, m_hi, m_lo, m_dz);
            check($sformatf("vec%0d_hi8", i), 64'(hi8), 64'(m_hi));
            check($sformatf("vec%0d_lo8", i), 64'(lo8), 64'(m_lo));
            check($sformatf("vec%0d_dz8", i), 64'(dz8), 64'(m_dz));
            check($sformatf("vec%0d_lat8", i), 64'(lat8), 64'(m_dz ? 1 : 9));
        end

        // done lasts a single cycle when no new request follows
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // A start arriving mid-RUN must not disturb the op in flight
        run_op(2'b00, 32'd15, 32'd12, 5, lat32, lat8, bcnt, dza);
        $display("inject op=0 a=0000000f b=0000000c -> hi=%h lo=%h lat=%0d", hi, lo, lat32);
        check("inject_hi", 64'(hi), 64'd0);
        check("inject_lo", 64'(lo), 64'd180);
        check("inject_lat", 64'(lat32), 64'd33);
        check("inject_busy", 64'(bcnt), 64'd33);

        // Back-to-back: start issued during the DONE cycle is accepted
        check("b2b_done_high", 64'(done), 64'd1);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, -1, lat32, lat8, bcnt, dza);
        $display("b2b op=1 a=fffffffd b=00000007 -> hi=%h lo=%h lat=%0d", hi, lo, lat32);
        check("b2b_hi", 64'(hi), 64'hFFFF_FFFF);
        check("b2b_lo", 64'(lo), 64'hFFFF_FFEB);
        check("b2b_lat", 64'(lat32), 64'd33);

        // kill at E0+10: busy drops, results keep old values, no done
        old_hi = 32'hFFFF_FFFF;
        old_lo = 32'hFFFF_FFEB;
        @(negedge clk);
        start = 1'b1; md_op = 2'b00; rs_content = 32'd1000; rt_content = 32'd3000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("kill_busy_before", 64'(busy), 64'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy_after", 64'(busy), 64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        $display("kill op=0 a=000003e8 b=00000bb8 -> hi=%h lo=%h done_seen=%0b", hi, lo, seen_done);
        check("kill_no_done", 64'(seen_done), 64'd0);
        check("kill_hi", 64'(hi), 64'(old_hi));
        check("kill_lo", 64'(lo), 64'(old_lo));

        // Randomized ops against the arithmetic model, both widths
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 40));
                default: ;
            endcase
            run_op(rop, ra, rb, -1, lat32, lat8, bcnt, dza);
            $display("rand %0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d", i, rop, ra, rb,
                     hi, lo, div_zero, lat32);
            ref_model(32, rop, ra, rb, m_hi, m_lo, m_dz);
            check($sformatf("rand%0d_hi", i), 64'(hi), 64'(m_hi));
            check($sformatf("rand%0d_lo", i), 64'(lo), 64'(m_lo));
            check($sformatf("rand%0d_dz", i), 64'(div_zero), 64'(m_dz));
            check($sformatf("rand%0d_lat", i), 64'(lat32), 64'(m_dz ? 1 : 33));
            ref_model(8, rop, ra, rb, m_hi, m_lo, m_dz);
            check($sformatf("rand%0d_hi8", i), 64'(hi8), 64'(m_hi));
            check($sformatf("rand%0d_lo8", i), 64'(lo8), 64'(m_lo));
            check($sformatf("rand%0d_dz8", i), 64'(dz8), 64'(m_dz));
            check($sformatf("rand%0d_lat8", i), 64'(lat8), 64'(m_dz ? 1 : 9));
        end

        // Asynchronous reset in the middle of RUN
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat32, lat8, bcnt, dza);
        check("prereset_lo", 64'(lo), 64'h1);
        @(negedge clk);
        start = 1'b1; md_op = 2'b00; rs_content = 32'd77; rt_content = 32'd99;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        $display("reset mid-run op=0 a=0000004d b=00000063 -> hi=%h lo=%h done_seen=%0b", hi, lo, seen_done);
        check("arst_no_done", 64'(seen_done), 64'd0);
        check("arst_idle_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
